tx_queue_sched: RTL and testbench
=================================

Name: tx_queue_sched

Overview:
- Transmit-side scheduler that shares one GMII transmit MAC between NQ output queues of the switch.
- Each queue is a descriptor FIFO (16-bit, length in [10:0]) plus a byte data FIFO, both with 1-cycle read latency.
- The block picks a queue per frame, strict-priority or weighted round-robin. It presents the winner to the MAC as a single ptr/data FIFO pair and holds the grant until the MAC has read exactly the descriptor's byte count.

Parameters:
- NQ, 4, number of queues (2..8).
- WW, 4, per-queue WRR weight width (frames per turn).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sched_mode  in  1  0 = strict priority (queue 0 highest), 1 = WRR.
- q_weight  in  NQ*WW  per-queue frame quantum; queue i at [i*WW +: WW].
- q_ptr_empty  in  NQ  per-queue descriptor FIFO empty.
- q_ptr_rd  out  NQ  per-queue descriptor read strobe.
- q_ptr_dout  in  NQ*16  per-queue descriptor FIFO output.
- q_data_rd  out  NQ  per-queue data read strobe.
- q_data_dout  in  NQ*8  per-queue data FIFO output.
- ptr_fifo_rd  in  1  descriptor read from MAC.
- ptr_fifo_din  out  16  descriptor to MAC (registered, held).
- ptr_fifo_empty  out  1  descriptor-available indication to MAC (active high = none).
- data_fifo_rd  in  1  byte read from MAC.
- data_fifo_din  out  8  byte to MAC (muxed by grant).
- grant  out  NQ  one-hot current/last grant.
- busy  out  1  high from grant until frame drained.
- proto_err  out  1  sticky; set on MAC read outside permitted window.

Behaviour:
- Reset (async, rstn low): state IDLE; grant = 0; ptr_fifo_din = 0; ptr_fifo_empty = 1; busy = 0; proto_err = 0; RR pointer = 0; all credits = 0; count = 0. Reset mid-frame abandons the frame, and upstream FIFOs are reset with it.
- States:
  - IDLE: if any q_ptr_empty[i] == 0, register the winner into grant, go GRANT (1-cycle arbitration latency).
  - GRANT: ptr_fifo_empty = q_ptr_empty[g]. When ptr_fifo_rd == 1: q_ptr_rd[g] = 1 (combinational pass-through), go LATCH.
  - LATCH: capture q_ptr_dout[g] into ptr_fifo_din and len = dout[10:0]; count = 0. If len == 0, go DRAIN; otherwise go XFER.
  - XFER: q_data_rd[g] = data_fifo_rd. Each data_fifo_rd cycle increments count (11-bit). The read with count == len-1 goes to DRAIN.
  - DRAIN: one cycle so the last byte (valid the cycle after the last read) still muxes from queue g; then IDLE.
- ptr_fifo_empty = 1 in every state except GRANT.
- busy = 1 in GRANT, LATCH, XFER and DRAIN.
- ptr_fifo_din holds the last descriptor until the next LATCH, because the MAC re-reads it after the data phase.
- data_fifo_din = q_data_dout[g], with g held until the next arbitration.
- No strobe reaches a non-granted queue.
- proto_err is set by:
  - ptr_fifo_rd outside GRANT;
  - data_fifo_rd outside XFER (that read is not forwarded).
- Strict priority: lowest-index non-empty queue wins.
- WRR arbitration:
  - Search starts at RR pointer p; the first non-empty queue in cyclic order p, p+1, ... wins.
  - If the winner differs from p, p jumps to the winner and credit is reloaded to max(q_weight, 1).
  - In LATCH, credit decrements.
  - In DRAIN, if credit == 0 or q_ptr_empty[g] == 1, p advances to g+1 mod NQ and credit reloads on next selection.
  - Weight 0 is treated as 1.
- sched_mode changes take effect only in IDLE; a frame in progress is never pre-empted.
- The queue's empty flag rising in GRANT (not expected) leaves ptr_fifo_empty high; the block waits in GRANT.

Decomposition:
- Package tx_sched_pkg:
  - state encoding (IDLE, GRANT, LATCH, XFER, DRAIN);
  - LEN_W = 11 and descriptor length field position [10:0];
  - default NQ and WW.
- Sub-module tx_sched_pick: combinational one-hot picker with inputs request vector, RR pointer and mode, output winner.
- Credit/pointer registers and the FSM live in the top module.

Test Plan:
- Single queue: q1 holds a descriptor len=64; MAC reads ptr, then 64 data reads. Required:
  - grant = 0010;
  - exactly one q_ptr_rd[1] and 64 q_data_rd[1];
  - ptr_fifo_din = descriptor held after DRAIN;
  - busy low 1 cycle after the last byte.
- Strict priority, queues 0 and 2 each with 3 frames of len=60: all 3 q0 frames are served before any q2 frame.
- WRR, weights {2,1,1,1}, all four queues backlogged: frame order 0,0,1,2,3,0,0,1,... Weight 0 on q3 yields one frame per turn.
- Zero-length descriptor on q0: LATCH goes to DRAIN with no q_data_rd; next arbitration occurs.
- Stray data_fifo_rd in IDLE and ptr_fifo_rd in XFER: proto_err latches 1; no queue strobe is generated; a subsequent frame completes normally.
- rstn pulsed low mid-XFER (count = 30 of 100): all outputs take reset values immediately; after release, the first arbitration restarts at queue 0 with p = 0.

Source files
------------

// File: rtl/tx_queue_sched_pkg.sv
// tx_sched_pkg: shared state encoding, descriptor layout and defaults for the tx scheduler
package tx_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LATCH, S_XFER, S_DRAIN} state_t;
  localparam int LEN_W   = 11;
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 10;
  localparam int DEF_NQ  = 4;
  localparam int DEF_WW  = 4;
  function automatic logic [LEN_W-1:0] desc_len(input logic [15:0] d);
    return d[LEN_MSB:LEN_LSB];
  endfunction
endpackage

// File: rtl/tx_queue_sched_if.sv
// tx_queue_sched_if: queue-side and MAC-side signals of the transmit scheduler
interface tx_queue_sched_if import tx_sched_pkg::*; #(
  parameter int NQ = DEF_NQ,
  parameter int WW = DEF_WW
) ();
  logic              sched_mode;
  logic [NQ*WW-1:0]  q_weight;
  logic [NQ-1:0]     q_ptr_empty;
  logic [NQ-1:0]     q_ptr_rd;
  logic [NQ*16-1:0]  q_ptr_dout;
  logic [NQ-1:0]     q_data_rd;
  logic [NQ*8-1:0]   q_data_dout;
  logic              ptr_fifo_rd;
  logic [15:0]       ptr_fifo_din;
  logic              ptr_fifo_empty;
  logic              data_fifo_rd;
  logic [7:0]        data_fifo_din;
  logic [NQ-1:0]     grant;
  logic              busy;
  logic              proto_err;
  modport master (
    input  sched_mode, q_weight, q_ptr_empty, q_ptr_dout, q_data_dout, ptr_fifo_rd, data_fifo_rd,
    output q_ptr_rd, q_data_rd, ptr_fifo_din, ptr_fifo_empty, data_fifo_din, grant, busy, proto_err
  );
  modport slave (
    output sched_mode, q_weight, q_ptr_empty, q_ptr_dout, q_data_dout, ptr_fifo_rd, data_fifo_rd,
    input  q_ptr_rd, q_data_rd, ptr_fifo_din, ptr_fifo_empty, data_fifo_din, grant, busy, proto_err
  );
endinterface

// File: rtl/tx_queue_sched_pick.sv
// tx_sched_pick: one-hot winner, lowest index (strict) or first from the RR pointer (WRR)
module tx_sched_pick import tx_sched_pkg::*; #(
  parameter int NQ = DEF_NQ,
  parameter int PW = $clog2(NQ)
) (
  input  logic [NQ-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_mode,
  output logic [NQ-1:0] o_win
);
  // scan from the far end so the highest-priority candidate is assigned last
  always_comb begin
    int j;
    o_win = '0;
    j = 0;
    for (int k = NQ - 1; k >= 0; k--) begin
      j = i_mode ? int'(i_ptr) + k : k;
      if (j >= NQ) j = j - NQ;
      if (i_req[j[PW-1:0]]) o_win = NQ'(1) << j[PW-1:0];
    end
  end
endmodule

// File: rtl/tx_queue_sched.sv
// tx_queue_sched: shares one GMII TX MAC between NQ queues, one whole frame per grant
module tx_queue_sched import tx_sched_pkg::*; #(
  parameter int NQ = DEF_NQ,
  parameter int WW = DEF_WW
) (
  input  logic         clk,
  input  logic         rstn,
  tx_queue_sched_if.master bus
);
  localparam int PW = $clog2(NQ);
  state_t           r_state, w_next;
  logic [NQ-1:0]    r_grant, w_win;
  logic [15:0]      r_desc, w_gdesc;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [PW-1:0]    r_rr, w_widx, w_gidx;
  logic [WW-1:0]    r_credit, w_wweight;
  logic             r_mode, r_perr, w_gempty, w_req_any;
  logic [7:0]       w_gdata;

  assign w_req_any          = |(~bus.q_ptr_empty);
  assign bus.grant          = r_grant;
  assign bus.ptr_fifo_din   = r_desc;
  assign bus.data_fifo_din  = w_gdata;
  assign bus.busy           = r_state != S_IDLE;
  assign bus.proto_err      = r_perr;

  tx_sched_pick #(.NQ(NQ), .PW(PW)) u_pick (
    .i_req  (~bus.q_ptr_empty),
    .i_ptr  (r_rr),
    .i_mode (bus.sched_mode),
    .o_win  (w_win)
  );

  // select the granted queue's signals and the candidate winner's index and weight
  always_comb begin
    w_gidx    = '0;
    w_gempty  = 1'b1;
    w_gdesc   = '0;
    w_gdata   = '0;
    w_widx    = '0;
    w_wweight = '0;
    for (int i = 0; i < NQ; i++) begin
      if (r_grant[i]) begin
        w_gidx   = PW'(i);
        w_gempty = bus.q_ptr_empty[i];
        w_gdesc  = bus.q_ptr_dout[i*16 +: 16];
        w_gdata  = bus.q_data_dout[i*8 +: 8];
      end
      if (w_win[i]) begin
        w_widx    = PW'(i);
        w_wweight = bus.q_weight[i*WW +: WW];
      end
    end
  end

  // next state and strobes; strobes only ever reach the granted queue
  always_comb begin
    w_next             = r_state;
    bus.q_ptr_rd       = '0;
    bus.q_data_rd      = '0;
    bus.ptr_fifo_empty = 1'b1;
    case (r_state)
      S_IDLE:  w_next = w_req_any ? S_GRANT : S_IDLE;
      S_GRANT: begin
        bus.ptr_fifo_empty = w_gempty;
        if (bus.ptr_fifo_rd && !w_gempty) begin
          bus.q_ptr_rd = r_grant;
          w_next       = S_LATCH;
        end
      end
      S_LATCH: w_next = desc_len(w_gdesc) == '0 ? S_DRAIN : S_XFER;
      S_XFER: begin
        bus.q_data_rd = bus.data_fifo_rd ? r_grant : '0;
        if (bus.data_fifo_rd && r_cnt == r_len - LEN_W'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state, grant, descriptor, byte count, WRR pointer/credit and sticky protocol error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_desc   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_rr     <= '0;
      r_credit <= '0;
      r_mode   <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((bus.ptr_fifo_rd && r_state != S_GRANT) || (bus.data_fifo_rd && r_state != S_XFER)) r_perr <= 1'b1;
      case (r_state)
        S_IDLE: if (w_req_any) begin
          r_grant <= w_win;
          r_mode  <= bus.sched_mode;
          if (bus.sched_mode && (w_widx != r_rr || r_credit == '0)) begin
            r_rr     <= w_widx;
            r_credit <= w_wweight == '0 ? WW'(1) : w_wweight;
          end
        end
        S_LATCH: begin
          r_desc <= w_gdesc;
          r_len  <= desc_len(w_gdesc);
          r_cnt  <= '0;
          if (r_mode && r_credit != '0) r_credit <= r_credit - WW'(1);
        end
        S_XFER: if (bus.data_fifo_rd) r_cnt <= r_cnt + LEN_W'(1);
        S_DRAIN: if (r_mode && (r_credit == '0 || w_gempty)) begin
          r_rr     <= w_gidx == PW'(NQ - 1) ? '0 : w_gidx + PW'(1);
          r_credit <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_queue_sched.sv
// tb_tx_queue_sched: directed frames through modelled queue FIFOs and a simple MAC
module tb_tx_queue_sched;
  localparam int NQ = 4;
  localparam int WW = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tx_queue_sched_if #(.NQ(NQ), .WW(WW)) bus ();
  tx_queue_sched #(.NQ(NQ), .WW(WW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  logic [15:0] pmem [NQ][64];
  logic [7:0]  dmem [NQ][1024];
  int pw [NQ] = '{default: 0};
  int pr [NQ] = '{default: 0};
  int dw [NQ] = '{default: 0};
  int dr [NQ] = '{default: 0};
  logic [15:0] pdout [NQ] = '{default: 16'h0};
  logic [7:0]  ddout [NQ] = '{default: 8'h0};
  int ptr_cnt [NQ] = '{default: 0};
  int data_cnt [NQ] = '{default: 0};
  int n_bad = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic w_bad;
  logic [3:0] wrr_exp [10];

  genvar g;
  for (g = 0; g < NQ; g++) begin : g_q
    assign bus.q_ptr_empty[g]          = (pr[g] == pw[g]);
    assign bus.q_ptr_dout[g*16 +: 16]  = pdout[g];
    assign bus.q_data_dout[g*8 +: 8]   = ddout[g];
  end

  always_comb w_bad = |((bus.q_ptr_rd | bus.q_data_rd) & ~bus.grant) | |(bus.q_ptr_rd & bus.q_ptr_empty);

  always @(posedge clk) begin
    if (w_bad) n_bad <= n_bad + 1;
    for (int q = 0; q < NQ; q++) begin
      if (bus.q_ptr_rd[q]) begin
        ptr_cnt[q] <= ptr_cnt[q] + 1;
        if (pr[q] != pw[q]) begin
          pdout[q] <= pmem[q][pr[q][5:0]];
          pr[q]    <= pr[q] + 1;
        end
      end
      if (bus.q_data_rd[q]) begin
        data_cnt[q] <= data_cnt[q] + 1;
        if (dr[q] != dw[q]) begin
          ddout[q] <= dmem[q][dr[q][9:0]];
          dr[q]    <= dr[q] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int q, input logic [15:0] desc);
    pmem[q][pw[q][5:0]] = desc;
    pw[q]++;
    for (int k = 0; k < int'(desc[10:0]); k++) begin
      dmem[q][dw[q][9:0]] = 8'(q * 16 + k);
      dw[q]++;
    end
  endtask

  function automatic int exp_sum(input int q, input int len);
    return len * q * 16 + len * (len - 1) / 2;
  endfunction

  task automatic mac_frame(input int stray_at, input int abort_at, output logic [15:0] desc, output int sum);
    int t;
    sum  = 0;
    desc = '0;
    t    = 0;
    while (bus.ptr_fifo_empty && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ptr_wait", 32'(!bus.ptr_fifo_empty), 1);
    if (bus.ptr_fifo_empty) return;
    bus.ptr_fifo_rd = 1'b1;
    @(negedge clk);
    bus.ptr_fifo_rd = 1'b0;
    @(negedge clk);
    desc = bus.ptr_fifo_din;
    for (int i = 0; i < int'(desc[10:0]); i++) begin
      if (i == abort_at) return;
      if (i == stray_at) begin
        bus.ptr_fifo_rd = 1'b1;
        @(negedge clk);
        bus.ptr_fifo_rd = 1'b0;
      end
      bus.data_fifo_rd = 1'b1;
      @(negedge clk);
      bus.data_fifo_rd = 1'b0;
      sum += int'(bus.data_fifo_din);
    end
  endtask

  initial begin
    logic [15:0] d;
    int s, pc, dc;
    wrr_exp = '{4'd1, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd1, 4'd2, 4'd4, 4'd8};
    bus.sched_mode   = 1'b0;
    bus.q_weight     = '0;
    bus.ptr_fifo_rd  = 1'b0;
    bus.data_fifo_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_din", 32'(bus.ptr_fifo_din), 0);
    check("rst_empty", 32'(bus.ptr_fifo_empty), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_perr", 32'(bus.proto_err), 0);
    check("rst_data", 32'(bus.data_fifo_din), 0);
    rstn = 1'b1;
    @(negedge clk);

    pc = ptr_cnt[1];
    dc = data_cnt[1];
    push_frame(1, 16'hA040);
    mac_frame(-1, -1, d, s);
    check("q1_grant", 32'(bus.grant), 32'h2);
    check("q1_desc", 32'(d), 32'hA040);
    check("q1_sum", s, exp_sum(1, 64));
    check("q1_drain_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("q1_idle_busy", 32'(bus.busy), 0);
    check("q1_desc_held", 32'(bus.ptr_fifo_din), 32'hA040);
    check("q1_empty_idle", 32'(bus.ptr_fifo_empty), 1);
    check("q1_ptr_rd", ptr_cnt[1] - pc, 1);
    check("q1_data_rd", data_cnt[1] - dc, 64);

    for (int f = 0; f < 3; f++) begin
      push_frame(0, 16'h003C);
      push_frame(2, 16'h003C);
    end
    for (int f = 0; f < 6; f++) begin
      mac_frame(-1, -1, d, s);
      check("sp_grant", 32'(bus.grant), f < 3 ? 1 : 4);
      check("sp_sum", s, exp_sum(f < 3 ? 0 : 2, 60));
    end
    @(negedge clk);

    bus.sched_mode = 1'b1;
    bus.q_weight   = 16'h1112;
    for (int f = 0; f < 4; f++) push_frame(0, 16'h0004);
    for (int f = 0; f < 2; f++) begin
      push_frame(1, 16'h0004);
      push_frame(2, 16'h0004);
      push_frame(3, 16'h0004);
    end
    for (int f = 0; f < 10; f++) begin
      mac_frame(-1, -1, d, s);
      check("wrr_grant", 32'(bus.grant), 32'(wrr_exp[f]));
    end
    @(negedge clk);

    bus.q_weight = 16'h0112;
    for (int f = 0; f < 2; f++) begin
      push_frame(1, 16'h0004);
      push_frame(3, 16'h0004);
    end
    for (int f = 0; f < 4; f++) begin
      mac_frame(-1, -1, d, s);
      check("w0_grant", 32'(bus.grant), f % 2 == 1 ? 8 : 2);
    end
    @(negedge clk);

    bus.sched_mode = 1'b0;
    dc = data_cnt[0];
    push_frame(0, 16'h5000);
    push_frame(0, 16'h0003);
    mac_frame(-1, -1, d, s);
    check("zl_desc", 32'(d), 32'h5000);
    check("zl_busy", 32'(bus.busy), 1);
    check("zl_no_data", data_cnt[0] - dc, 0);
    mac_frame(-1, -1, d, s);
    check("zl_next_grant", 32'(bus.grant), 1);
    check("zl_next_sum", s, exp_sum(0, 3));
    check("zl_next_data", data_cnt[0] - dc, 3);
    @(negedge clk);

    check("perr_clear", 32'(bus.proto_err), 0);
    dc = data_cnt[0] + data_cnt[1] + data_cnt[2] + data_cnt[3];
    bus.data_fifo_rd = 1'b1;
    @(negedge clk);
    bus.data_fifo_rd = 1'b0;
    check("perr_idle_data", 32'(bus.proto_err), 1);
    check("perr_no_strobe", data_cnt[0] + data_cnt[1] + data_cnt[2] + data_cnt[3] - dc, 0);
    check("perr_busy", 32'(bus.busy), 0);
    push_frame(2, 16'h0008);
    mac_frame(-1, -1, d, s);
    check("perr_frame_grant", 32'(bus.grant), 4);
    check("perr_frame_sum", s, exp_sum(2, 8));
    @(negedge clk);

    bus.sched_mode = 1'b1;
    push_frame(3, 16'h0064);
    mac_frame(-1, 30, d, s);
    check("mid_desc", 32'(d), 32'h0064);
    check("mid_busy", 32'(bus.busy), 1);
    rstn = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_grant", 32'(bus.grant), 0);
    check("arst_din", 32'(bus.ptr_fifo_din), 0);
    check("arst_empty", 32'(bus.ptr_fifo_empty), 1);
    check("arst_perr", 32'(bus.proto_err), 0);
    for (int q = 0; q < NQ; q++) begin
      pw[q] = pr[q];
      dw[q] = dr[q];
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push_frame(0, 16'h0005);
    push_frame(3, 16'h0006);
    mac_frame(-1, -1, d, s);
    check("rst_restart_grant", 32'(bus.grant), 1);
    check("rst_restart_sum", s, exp_sum(0, 5));
    check("rst_restart_perr", 32'(bus.proto_err), 0);
    pc = ptr_cnt[3];
    mac_frame(2, -1, d, s);
    check("perr_xfer_grant", 32'(bus.grant), 8);
    check("perr_xfer_sum", s, exp_sum(3, 6));
    check("perr_xfer_set", 32'(bus.proto_err), 1);
    check("perr_xfer_ptr_rd", ptr_cnt[3] - pc, 1);
    @(negedge clk);
    check("end_busy", 32'(bus.busy), 0);
    check("stray_strobes", n_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
